axi_rd_arb: RTL and testbench

- Read-channel arbiter between the instruction-cache refill port and the data-cache refill/uncached-load port.
- Both share the single AXI3 AR/R channel pair at the core boundary.
- Registers one AR request at a time under round-robin arbitration and stamps the AXI ID.
- Returns R beats to the owning requester by rid, and tracks outstanding bursts per requester.

---
 rtl/axi_rd_arb.sv | 138 +++++++++++++
 tb/tb_axi_rd_arb.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arb.sv
// axi_rd_arb: AXI3 read-channel arbiter between the icache refill port and the dcache refill/uncached-load port
//   aclk, aresetn                : clock, asynchronous active-low reset
//   i_ar* / d_ar*                : requester AR channels (valid/ready/addr/len/size)
//   ar*                          : shared AXI AR channel, one registered request at a time
//   r*                           : shared AXI R channel
//   i_r* / d_r*                  : per-requester R channels, routed by rid
//   err_rid                      : pulse on an R beat with an unknown rid or an unmatched rlast
module axi_rd_arb #(
    parameter int         PA_W      = 32,
    parameter int         DATA_W    = 64,
    parameter logic [3:0] I_ID      = 4'd0,
    parameter logic [3:0] D_ID      = 4'd1,
    parameter int         MAX_OUTST = 2
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              i_arvalid,
    output logic              i_arready,
    input  logic [PA_W-1:0]   i_araddr,
    input  logic [3:0]        i_arlen,
    input  logic [2:0]        i_arsize,
    input  logic              d_arvalid,
    output logic              d_arready,
    input  logic [PA_W-1:0]   d_araddr,
    input  logic [3:0]        d_arlen,
    input  logic [2:0]        d_arsize,
    output logic              arvalid,
    input  logic              arready,
    output logic [3:0]        arid,
    output logic [PA_W-1:0]   araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    output logic              rready,
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    output logic              i_rvalid,
    input  logic              i_rready,
    output logic [DATA_W-1:0] i_rdata,
    output logic [1:0]        i_rresp,
    output logic              i_rlast,
    output logic              d_rvalid,
    input  logic              d_rready,
    output logic [DATA_W-1:0] d_rdata,
    output logic [1:0]        d_rresp,
    output logic              d_rlast,
    output logic              err_rid
);
    localparam int            CW   = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_OUTST);
    logic            r_slot_valid;
    logic [3:0]      r_arid;
    logic [PA_W-1:0] r_araddr;
    logic [3:0]      r_arlen;
    logic [2:0]      r_arsize;
    logic            r_rr_i;
    logic [CW-1:0]   r_cnt_i;
    logic [CW-1:0]   r_cnt_d;
    logic            w_free;
    logic            w_elig_i;
    logic            w_elig_d;
    logic            w_grant_i;
    logic            w_grant_d;
    logic            w_rid_i;
    logic            w_rid_d;
    logic            w_dec_i;
    logic            w_dec_d;
    // Hold-at-zero on a retire with nothing outstanding; simultaneous +1/-1 cancels.
    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c, input logic inc, input logic dec);
        return (inc && !dec) ? c + CW'(1) :
               (dec && !inc && c != '0) ? c - CW'(1) : c;
    endfunction
    // Slot can be reloaded in the same cycle it hands off, so no bubble between bursts.
    assign w_free    = !r_slot_valid || arready;
    assign w_elig_i  = i_arvalid && (r_cnt_i < MAXC);
    assign w_elig_d  = d_arvalid && (r_cnt_d < MAXC);
    assign w_grant_i = w_free && w_elig_i && (!w_elig_d || r_rr_i);
    assign w_grant_d = w_free && w_elig_d && (!w_elig_i || !r_rr_i);
    // Gated by aresetn so the handshake outputs read as idle while reset is held.
    assign i_arready = aresetn && w_grant_i;
    assign d_arready = aresetn && w_grant_d;
    assign arvalid   = r_slot_valid;
    assign arid      = r_arid;
    assign araddr    = r_araddr;
    assign arlen     = r_arlen;
    assign arsize    = r_arsize;
    assign arburst   = 2'b01;
    assign w_rid_i   = rid == I_ID;
    assign w_rid_d   = !w_rid_i && rid == D_ID;
    // Unknown ids are sunk so a stray beat cannot stall the shared R channel.
    assign rready    = w_rid_i ? i_rready : w_rid_d ? d_rready : 1'b1;
    assign i_rvalid  = rvalid && w_rid_i;
    assign d_rvalid  = rvalid && w_rid_d;
    assign i_rdata   = rdata;
    assign d_rdata   = rdata;
    assign i_rresp   = rresp;
    assign d_rresp   = rresp;
    assign i_rlast   = rlast;
    assign d_rlast   = rlast;
    assign w_dec_i   = rvalid && rready && rlast && w_rid_i;
    assign w_dec_d   = rvalid && rready && rlast && w_rid_d;
    assign err_rid   = aresetn && ((rvalid && !w_rid_i && !w_rid_d) ||
                                   (w_dec_i && r_cnt_i == '0) || (w_dec_d && r_cnt_d == '0));
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_slot_valid <= 1'b0;
            r_arid       <= '0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arsize     <= '0;
            r_rr_i       <= 1'b1;
            r_cnt_i      <= '0;
            r_cnt_d      <= '0;
        end else begin
            if (w_free) begin
                r_slot_valid <= w_grant_i || w_grant_d;
                if (w_grant_i) begin
                    r_arid   <= I_ID;
                    r_araddr <= i_araddr;
                    r_arlen  <= i_arlen;
                    r_arsize <= i_arsize;
                    r_rr_i   <= 1'b0;
                end else if (w_grant_d) begin
                    r_arid   <= D_ID;
                    r_araddr <= d_araddr;
                    r_arlen  <= d_arlen;
                    r_arsize <= d_arsize;
                    r_rr_i   <= 1'b1;
                end
            end
            r_cnt_i <= cnt_next(r_cnt_i, w_grant_i, w_dec_i);
            r_cnt_d <= cnt_next(r_cnt_d, w_grant_d, w_dec_d);
        end
    end
endmodule

// File: tb/tb_axi_rd_arb.sv
// tb_axi_rd_arb: directed vector table plus reset / burst sequences for axi_rd_arb
module tb_axi_rd_arb;
    localparam logic [31:0] IA = 32'h1C00_0000;
    localparam logic [31:0] DA = 32'h2000_0040;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        i_arvalid, i_arready, d_arvalid, d_arready;
    logic [31:0] i_araddr, d_araddr, araddr;
    logic [3:0]  i_arlen, d_arlen, arlen, arid, rid;
    logic [2:0]  i_arsize, d_arsize, arsize;
    logic        arvalid, arready;
    logic [1:0]  arburst, rresp, i_rresp, d_rresp;
    logic        rvalid, rready, rlast;
    logic [63:0] rdata, i_rdata, d_rdata;
    logic        i_rvalid, i_rready, i_rlast, d_rvalid, d_rready, d_rlast, err_rid;
    int          n_tot = 0;
    int          n_pass = 0;

    typedef struct {
        logic       ia, da, ardy, rv;
        logic [3:0] rid;
        logic       rl, irr, drr;
        logic       e_iar, e_dar, e_av;
        logic [3:0] e_id;
        logic       e_irv, e_drv, e_rr, e_err;
    } vec_t;
    vec_t vt [24];

    axi_rd_arb dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_arvalid(i_arvalid), .i_arready(i_arready), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .d_arvalid(d_arvalid), .d_arready(d_arready), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
        .d_rvalid(d_rvalid), .d_rready(d_rready), .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rlast(d_rlast),
        .err_rid(err_rid)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_tot++;
        if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
        else n_pass++;
    endtask

    task automatic drive(input logic ia, input logic da, input logic ardy, input logic rv,
                         input logic [3:0] r_id, input logic rl, input logic irr, input logic drr);
        i_arvalid = ia; d_arvalid = da; arready = ardy; rvalid = rv;
        rid = r_id; rlast = rl; i_rready = irr; d_rready = drr;
    endtask

    task automatic chk_idle(input string n);
        chk({n, " arvalid"}, 64'(arvalid), 64'd0);
        chk({n, " arid"}, 64'(arid), 64'd0);
        chk({n, " araddr"}, 64'(araddr), 64'd0);
        chk({n, " arlen"}, 64'(arlen), 64'd0);
        chk({n, " arsize"}, 64'(arsize), 64'd0);
        chk({n, " arburst"}, 64'(arburst), 64'd1);
        chk({n, " i_arready"}, 64'(i_arready), 64'd0);
        chk({n, " d_arready"}, 64'(d_arready), 64'd0);
        chk({n, " err_rid"}, 64'(err_rid), 64'd0);
    endtask

    initial begin
        //        ia da ar rv rid   rl ir dr   eia eda eav eid   eirv edrv err  eerr
        vt[0]  = '{1, 0, 1, 0, 4'd0, 0, 0, 0,  1, 0, 0, 4'd0, 0, 0, 0, 0};
        vt[1]  = '{0, 0, 0, 0, 4'd0, 0, 0, 0,  0, 0, 1, 4'd0, 0, 0, 0, 0};
        vt[2]  = '{1, 1, 0, 0, 4'd0, 0, 0, 0,  0, 0, 1, 4'd0, 0, 0, 0, 0};
        vt[3]  = '{1, 1, 1, 0, 4'd0, 0, 0, 0,  0, 1, 1, 4'd0, 0, 0, 0, 0};
        vt[4]  = '{1, 1, 1, 0, 4'd0, 0, 0, 0,  1, 0, 1, 4'd1, 0, 0, 0, 0};
        vt[5]  = '{1, 1, 1, 0, 4'd0, 0, 0, 0,  0, 1, 1, 4'd0, 0, 0, 0, 0};
        vt[6]  = '{1, 1, 1, 0, 4'd0, 0, 0, 0,  0, 0, 1, 4'd1, 0, 0, 0, 0};
        vt[7]  = '{1, 1, 1, 1, 4'd0, 0, 1, 0,  0, 0, 0, 4'd0, 1, 0, 1, 0};
        vt[8]  = '{1, 1, 1, 1, 4'd0, 1, 0, 0,  0, 0, 0, 4'd0, 1, 0, 0, 0};
        vt[9]  = '{1, 1, 1, 1, 4'd0, 1, 1, 0,  0, 0, 0, 4'd0, 1, 0, 1, 0};
        vt[10] = '{1, 1, 1, 0, 4'd0, 0, 0, 0,  1, 0, 0, 4'd0, 0, 0, 0, 0};
        vt[11] = '{1, 1, 1, 1, 4'd0, 1, 1, 0,  0, 0, 1, 4'd0, 1, 0, 1, 0};
        vt[12] = '{1, 0, 1, 1, 4'd0, 1, 1, 0,  1, 0, 0, 4'd0, 1, 0, 1, 0};
        vt[13] = '{1, 0, 1, 0, 4'd0, 0, 0, 0,  1, 0, 1, 4'd0, 0, 0, 0, 0};
        vt[14] = '{1, 0, 1, 0, 4'd0, 0, 0, 0,  0, 0, 1, 4'd0, 0, 0, 0, 0};
        vt[15] = '{0, 0, 1, 1, 4'd7, 1, 0, 0,  0, 0, 0, 4'd0, 0, 0, 1, 1};
        vt[16] = '{0, 0, 1, 1, 4'd1, 1, 0, 1,  0, 0, 0, 4'd0, 0, 1, 1, 0};
        vt[17] = '{1, 1, 1, 0, 4'd0, 0, 0, 0,  0, 1, 0, 4'd0, 0, 0, 0, 0};
        vt[18] = '{0, 0, 0, 1, 4'd1, 1, 0, 1,  0, 0, 1, 4'd1, 0, 1, 1, 0};
        vt[19] = '{0, 0, 0, 1, 4'd1, 1, 0, 1,  0, 0, 1, 4'd1, 0, 1, 1, 0};
        vt[20] = '{0, 0, 0, 1, 4'd1, 1, 0, 1,  0, 0, 1, 4'd1, 0, 1, 1, 1};
        vt[21] = '{0, 1, 1, 0, 4'd0, 0, 0, 0,  0, 1, 1, 4'd1, 0, 0, 0, 0};
        vt[22] = '{0, 1, 1, 0, 4'd0, 0, 0, 0,  0, 1, 1, 4'd1, 0, 0, 0, 0};
        vt[23] = '{0, 1, 1, 0, 4'd0, 0, 0, 0,  0, 0, 1, 4'd1, 0, 0, 0, 0};

        i_araddr = IA; i_arlen = 4'd3; i_arsize = 3'd3;
        d_araddr = DA; d_arlen = 4'd7; d_arsize = 3'd2;
        rdata = 64'h0; rresp = 2'b10;
        aresetn = 1'b0;
        drive(1, 1, 1, 1, 4'd7, 1, 1, 1);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk_idle("in_reset");
        drive(0, 0, 0, 0, 4'd0, 0, 0, 0);
        @(posedge aclk);
        #1 aresetn = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(posedge aclk);
            #1;
            drive(vt[i].ia, vt[i].da, vt[i].ardy, vt[i].rv, vt[i].rid, vt[i].rl, vt[i].irr, vt[i].drr);
            rdata = {32'hCAFE_0000, 32'(i)};
            @(negedge aclk);
            chk($sformatf("v%0d i_arready", i), 64'(i_arready), 64'(vt[i].e_iar));
            chk($sformatf("v%0d d_arready", i), 64'(d_arready), 64'(vt[i].e_dar));
            chk($sformatf("v%0d arvalid", i), 64'(arvalid), 64'(vt[i].e_av));
            if (vt[i].e_av) begin
                chk($sformatf("v%0d arid", i), 64'(arid), 64'(vt[i].e_id));
                chk($sformatf("v%0d araddr", i), 64'(araddr), 64'(vt[i].e_id == 4'd0 ? IA : DA));
                chk($sformatf("v%0d arlen", i), 64'(arlen), 64'(vt[i].e_id == 4'd0 ? 4'd3 : 4'd7));
            end
            chk($sformatf("v%0d i_rvalid", i), 64'(i_rvalid), 64'(vt[i].e_irv));
            chk($sformatf("v%0d d_rvalid", i), 64'(d_rvalid), 64'(vt[i].e_drv));
            chk($sformatf("v%0d rready", i), 64'(rready), 64'(vt[i].e_rr));
            chk($sformatf("v%0d err_rid", i), 64'(err_rid), 64'(vt[i].e_err));
            chk($sformatf("v%0d i_rdata", i), i_rdata, rdata);
            chk($sformatf("v%0d d_rlast", i), 64'(d_rlast), 64'(vt[i].rl));
            chk($sformatf("v%0d i_rresp", i), 64'(i_rresp), 64'd2);
        end

        // retire one icache burst, then load a slot that stays stuck behind arready=0
        @(posedge aclk); #1 drive(0, 0, 0, 1, 4'd0, 1, 1, 0);
        @(posedge aclk); #1 drive(1, 0, 0, 0, 4'd0, 0, 0, 0);
        @(negedge aclk);
        chk("pre_rst i_arready", 64'(i_arready), 64'd1);
        @(posedge aclk); #1 drive(1, 1, 0, 1, 4'd7, 0, 0, 0);
        @(negedge aclk);
        chk("pre_rst arvalid", 64'(arvalid), 64'd1);
        #1 aresetn = 1'b0;
        #1 chk_idle("async_rst");
        @(posedge aclk); #1 drive(0, 0, 0, 0, 4'd0, 0, 0, 0);
        aresetn = 1'b1;

        // fresh contention after reset: icache is favoured
        @(posedge aclk); #1 drive(1, 1, 1, 0, 4'd0, 0, 0, 0);
        @(negedge aclk);
        chk("post_rst i_arready", 64'(i_arready), 64'd1);
        chk("post_rst d_arready", 64'(d_arready), 64'd0);
        @(posedge aclk); #1 drive(0, 0, 0, 0, 4'd0, 0, 0, 0);
        @(negedge aclk);
        chk("single arvalid", 64'(arvalid), 64'd1);
        chk("single arid", 64'(arid), 64'd0);
        chk("single araddr", 64'(araddr), 64'(IA));
        chk("single arlen", 64'(arlen), 64'd3);
        chk("single arsize", 64'(arsize), 64'd3);
        for (int b = 0; b < 4; b++) begin
            @(posedge aclk); #1 drive(0, 0, 1, 1, 4'd0, b == 3, 1, 0);
            rdata = 64'hBEEF_0000_0000_0000 | 64'(b);
            @(negedge aclk);
            chk($sformatf("beat%0d i_rvalid", b), 64'(i_rvalid), 64'd1);
            chk($sformatf("beat%0d d_rvalid", b), 64'(d_rvalid), 64'd0);
            chk($sformatf("beat%0d i_rlast", b), 64'(i_rlast), 64'(b == 3));
            chk($sformatf("beat%0d i_rdata", b), i_rdata, 64'hBEEF_0000_0000_0000 | 64'(b));
            chk($sformatf("beat%0d rready", b), 64'(rready), 64'd1);
        end
        // icache counter is back to zero: exactly two more grants fit
        for (int g = 0; g < 3; g++) begin
            @(posedge aclk); #1 drive(1, 0, 1, 0, 4'd0, 0, 0, 0);
            @(negedge aclk);
            chk($sformatf("refill%0d i_arready", g), 64'(i_arready), 64'(g < 2));
        end
        @(posedge aclk); #1 drive(0, 0, 0, 0, 4'd0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
